// File: rtl/mem18_arbiter.sv
// Two-requester burst arbiter and sequencer for the single-port 18x256 block RAM memory18.
// Define MEM18_ARB_FIXED_PRIO_EN for fixed A-over-B priority in place of round-robin.
module mem18_arbiter #(
    parameter int unsigned RAM_WIDTH     = 18,
    parameter int unsigned RAM_ADDR_BITS = 8,
    parameter int unsigned LEN_BITS      = 4
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [RAM_ADDR_BITS-1:0] a_addr,
    input  logic [LEN_BITS-1:0]      a_len,
    output logic                     a_ack,
    input  logic [RAM_WIDTH-1:0]     a_wdata,
    output logic                     a_wready,
    output logic [RAM_WIDTH-1:0]     a_rdata,
    output logic                     a_rvalid,
    output logic                     a_done,

    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [RAM_ADDR_BITS-1:0] b_addr,
    input  logic [LEN_BITS-1:0]      b_len,
    output logic                     b_ack,
    input  logic [RAM_WIDTH-1:0]     b_wdata,
    output logic                     b_wready,
    output logic [RAM_WIDTH-1:0]     b_rdata,
    output logic                     b_rvalid,
    output logic                     b_done,

    output logic                     mem_ramEN,
    output logic                     mem_writeEN,
    output logic                     mem_readEN,
    output logic [RAM_ADDR_BITS-1:0] mem_addr,
    output logic [RAM_WIDTH-1:0]     mem_data_in,
    input  logic [RAM_WIDTH-1:0]     mem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_owner;      // 0 = A, 1 = B
    logic                     r_we;
    logic [RAM_ADDR_BITS-1:0] r_addr;
    logic [LEN_BITS-1:0]      r_cnt;
    logic                     r_rd_pend;    // a read strobe was issued last cycle
    logic [RAM_WIDTH-1:0]     r_a_rdata;
    logic [RAM_WIDTH-1:0]     r_b_rdata;

    logic                     w_accept;
    logic                     w_pick_b;
    logic                     w_in_burst;
    logic                     w_done;

`ifdef MEM18_ARB_FIXED_PRIO_EN
    always_comb begin
        w_pick_b = b_req & ~a_req;
    end
`else
    logic r_prio;                           // 1 = B has priority on a tie

    always_comb begin
        w_pick_b = b_req & (~a_req | r_prio);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_done) begin
            r_prio <= ~r_owner;
        end
    end
`endif

    // Next state and all outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_in_burst  = 1'b0;
        w_done      = 1'b0;
        a_ack       = 1'b0;
        b_ack       = 1'b0;
        a_wready    = 1'b0;
        b_wready    = 1'b0;
        a_rvalid    = 1'b0;
        b_rvalid    = 1'b0;
        a_done      = 1'b0;
        b_done      = 1'b0;
        a_rdata     = r_a_rdata;
        b_rdata     = r_b_rdata;
        mem_ramEN   = 1'b0;
        mem_writeEN = 1'b0;
        mem_readEN  = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;

        case (r_state)
            S_IDLE: begin
                if (a_req || b_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                w_in_burst = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = r_we ? S_IDLE : S_DRAIN;
                    w_done      = r_we;
                end
            end
            S_DRAIN: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        a_ack = w_accept & ~w_pick_b;
        b_ack = w_accept & w_pick_b;

        if (w_in_burst) begin
            mem_ramEN   = 1'b1;
            mem_writeEN = r_we;
            mem_readEN  = ~r_we;
            mem_addr    = r_addr;
            if (r_we) begin
                mem_data_in = r_owner ? b_wdata : a_wdata;
            end
        end

        a_wready = w_in_burst & r_we & ~r_owner;
        b_wready = w_in_burst & r_we & r_owner;
        a_rvalid = r_rd_pend & ~r_owner;
        b_rvalid = r_rd_pend & r_owner;
        a_done   = w_done & ~r_owner;
        b_done   = w_done & r_owner;

        // RAM output register is live on rvalid cycles; hold copy otherwise.
        if (a_rvalid) begin
            a_rdata = mem_data_out;
        end
        if (b_rvalid) begin
            b_rdata = mem_data_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst context: latched on accept, stepped once per RAM access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_in_burst & ~r_we;
            if (w_accept) begin
                r_owner <= w_pick_b;
                r_we    <= w_pick_b ? b_we   : a_we;
                r_addr  <= w_pick_b ? b_addr : a_addr;
                r_cnt   <= w_pick_b ? b_len  : a_len;
            end else if (w_in_burst) begin
                r_addr <= r_addr + RAM_ADDR_BITS'(1);
                r_cnt  <= r_cnt - LEN_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (a_rvalid) begin
                r_a_rdata <= mem_data_out;
            end
            if (b_rvalid) begin
                r_b_rdata <= mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_mem18_arbiter.sv
// Directed self-checking bench for mem18_arbiter with a behavioural memory18 model.
module tb_mem18_arbiter;

    localparam int unsigned W  = 18;
    localparam int unsigned AB = 8;
    localparam int unsigned LB = 4;

`ifdef MEM18_ARB_FIXED_PRIO_EN
    localparam logic [3:0] ARB_EXP = 4'b0000;
`else
    localparam logic [3:0] ARB_EXP = 4'b1010;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, a_ack, a_wready, a_rvalid, a_done;
    logic [AB-1:0] a_addr;
    logic [LB-1:0] a_len;
    logic [W-1:0]  a_wdata, a_rdata;
    logic          b_req, b_we, b_ack, b_wready, b_rvalid, b_done;
    logic [AB-1:0] b_addr;
    logic [LB-1:0] b_len;
    logic [W-1:0]  b_wdata, b_rdata;
    logic          mem_ramEN, mem_writeEN, mem_readEN;
    logic [AB-1:0] mem_addr;
    logic [W-1:0]  mem_data_in, mem_data_out;

    logic [W-1:0]  ram [256];
    logic [W-1:0]  wexp [16];
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    mem18_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .LEN_BITS(LB)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_len(a_len), .a_ack(a_ack),
        .a_wdata(a_wdata), .a_wready(a_wready), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .a_done(a_done),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_len(b_len), .b_ack(b_ack),
        .b_wdata(b_wdata), .b_wready(b_wready), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .b_done(b_done),
        .mem_ramEN(mem_ramEN), .mem_writeEN(mem_writeEN), .mem_readEN(mem_readEN),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // memory18: registered read, one-cycle latency
    always @(posedge clk) begin
        if (mem_ramEN && mem_writeEN) ram[mem_addr] <= mem_data_in;
        if (mem_ramEN && mem_readEN)  mem_data_out  <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic sel1(input bit side, input logic a, input logic b);
        return side ? b : a;
    endfunction

    function automatic logic [W-1:0] sel18(input bit side, input logic [W-1:0] a, input logic [W-1:0] b);
        return side ? b : a;
    endfunction

    task automatic drive_req(input bit side, input logic req, input logic we,
                             input logic [AB-1:0] addr, input logic [LB-1:0] len);
        if (side) begin
            b_req = req; b_we = we; b_addr = addr; b_len = len;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_len = len;
        end
    endtask

    // Raise req, wait (bounded) for the ack, release req after the accepting edge.
    task automatic start_burst(input bit side, input logic we,
                               input logic [AB-1:0] addr, input logic [LB-1:0] len);
        @(negedge clk);
        drive_req(side, 1'b1, we, addr, len);
        #1;
        for (int w = 0; w < 4 && !sel1(side, a_ack, b_ack); w++) begin
            @(negedge clk);
            #1;
        end
        check("ack_owner", 32'(sel1(side, a_ack, b_ack)), 32'd1);
        check("ack_other", 32'(sel1(side, b_ack, a_ack)), 32'd0);
        check("ack_no_strobe", 32'(mem_ramEN), 32'd0);
        @(posedge clk);
        #1;
        drive_req(side, 1'b0, we, addr, len);
    endtask

    task automatic write_beats(input bit side, input logic [AB-1:0] addr, input int len);
        for (int i = 0; i <= len; i++) begin
            @(negedge clk);
            if (side) b_wdata = wexp[i]; else a_wdata = wexp[i];
            #1;
            check("wr_wready", 32'(sel1(side, a_wready, b_wready)), 32'd1);
            check("wr_we", 32'(mem_writeEN), 32'd1);
            check("wr_addr", 32'(mem_addr), 32'(AB'(addr + AB'(i))));
            check("wr_data", 32'(mem_data_in), 32'(wexp[i]));
            check("wr_done", 32'(sel1(side, a_done, b_done)), 32'(i == len));
        end
        @(negedge clk);
        #1;
        check("wr_gap_en", 32'(mem_ramEN), 32'd0);
        check("wr_gap_wready", 32'(sel1(side, a_wready, b_wready)), 32'd0);
    endtask

    task automatic read_beats(input bit side, input logic [AB-1:0] addr, input int len);
        @(negedge clk);
        #1;
        check("rd_strobe", 32'(mem_readEN), 32'd1);
        check("rd_addr0", 32'(mem_addr), 32'(addr));
        check("rd_early_rvalid", 32'(sel1(side, a_rvalid, b_rvalid)), 32'd0);
        for (int i = 0; i <= len; i++) begin
            @(negedge clk);
            #1;
            check("rd_rvalid", 32'(sel1(side, a_rvalid, b_rvalid)), 32'd1);
            check("rd_data", 32'(sel18(side, a_rdata, b_rdata)), 32'(wexp[i]));
            check("rd_done", 32'(sel1(side, a_done, b_done)), 32'(i == len));
            check("rd_en", 32'(mem_ramEN), 32'(i < len));
            check("rd_other_rvalid", 32'(sel1(side, b_rvalid, a_rvalid)), 32'd0);
        end
        @(negedge clk);
        #1;
        check("rd_after_rvalid", 32'(sel1(side, a_rvalid, b_rvalid)), 32'd0);
        check("rd_hold", 32'(sel18(side, a_rdata, b_rdata)), 32'(wexp[len]));
        check("rd_after_done", 32'(sel1(side, a_done, b_done)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic g [4];
        int   ng;
        rst = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_len = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_len = '0; b_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_en", 32'(mem_ramEN), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_a_rdata", 32'(a_rdata), 32'd0);
        check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // A: 4-beat write at 0x10, then read back
        for (int i = 0; i < 4; i++) wexp[i] = W'(i + 1);
        start_burst(1'b0, 1'b1, 8'h10, 4'd3);
        write_beats(1'b0, 8'h10, 3);
        start_burst(1'b0, 1'b0, 8'h10, 4'd3);
        read_beats(1'b0, 8'h10, 3);
        check("nonowner_rdata", 32'(b_rdata), 32'd0);

        // B: 3-beat write wrapping 0xFE -> 0x00, then read back
        wexp[0] = 18'h12345; wexp[1] = 18'h0ABCD; wexp[2] = 18'h3C3C3;
        start_burst(1'b1, 1'b1, 8'hFE, 4'd2);
        write_beats(1'b1, 8'hFE, 2);
        start_burst(1'b1, 1'b0, 8'hFE, 4'd2);
        read_beats(1'b1, 8'hFE, 2);

        // Both requesters held high, single-beat writes
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 8'h40; a_len = '0; a_wdata = 18'h00AAA;
        b_req = 1; b_we = 1; b_addr = 8'h50; b_len = '0; b_wdata = 18'h00BBB;
        ng = 0;
        for (int c = 0; c < 16 && ng < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check("arb_one_ack", 32'(a_ack & b_ack), 32'd0);
            if (a_ack) begin g[ng] = 1'b0; ng++; end
            else if (b_ack) begin g[ng] = 1'b1; ng++; end
        end
        @(posedge clk);
        #1;
        a_req = 0; b_req = 0;
        check("arb_grants", 32'(ng), 32'd4);
        for (int k = 0; k < ng; k++) check("arb_order", 32'(g[k]), 32'(ARB_EXP[k]));

        // Single-beat read at 0x80 passes through DRAIN
        wexp[0] = 18'h3FFFF;
        start_burst(1'b0, 1'b1, 8'h80, 4'd0);
        write_beats(1'b0, 8'h80, 0);
        start_burst(1'b0, 1'b0, 8'h80, 4'd0);
        read_beats(1'b0, 8'h80, 0);

        // Reset during beat 2 of a 16-beat write
        start_burst(1'b0, 1'b1, 8'h20, 4'd15);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a_wdata = W'(18'h100 + i);
            #1;
            check("rstb_wready", 32'(a_wready), 32'd1);
        end
        rst = 1'b1;
        #1;
        check("rstb_wready0", 32'(a_wready), 32'd0);
        check("rstb_en0", 32'(mem_ramEN), 32'd0);
        check("rstb_we0", 32'(mem_writeEN), 32'd0);
        check("rstb_addr0", 32'(mem_addr), 32'd0);
        check("rstb_din0", 32'(mem_data_in), 32'd0);
        check("rstb_done0", 32'(a_done), 32'd0);
        check("rstb_rdata0", 32'(a_rdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("rstb_no_done", 32'(a_done | b_done), 32'd0);
        end
        b_req = 1; b_we = 1; b_addr = 8'h60; b_len = '0;
        start_burst(1'b0, 1'b1, 8'h30, 4'd0);
        b_req = 0;
        wexp[0] = 18'h00123;
        write_beats(1'b0, 8'h30, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
